// File: rtl/or_mul_pkg.sv
// Shared types and constants for the OR-based sequential multiplier controller.
package or_mul_pkg;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

    localparam int NIB  = 4;
    localparam int SUBW = 8;

    function automatic int nibble_count(input int n);
        return n / NIB;
    endfunction

endpackage

// File: rtl/or_4x4.sv
// Approximate 4x4 multiplier: partial products are merged with OR instead of added.
module or_4x4
    import or_mul_pkg::*;
(
    input  logic [NIB-1:0]  a_i,
    input  logic [NIB-1:0]  b_i,
    output logic [SUBW-1:0] p_o
);

    // Bit 7 is tied high, so every approximate sub-product is at least 0x80.
    always_comb begin
        p_o = 8'h80;
        for (int j = 0; j < NIB; j++) begin
            if (b_i[j]) begin
                p_o[6:0] = p_o[6:0] | (7'(a_i) << j);
            end
        end
    end

endmodule

// File: rtl/or_mul_seq_ctrl.sv
// Sequential multiplier: one shared 4x4 core walks every nibble pair and
// shift-accumulates the sub-products into a 2N-bit result.
module or_mul_seq_ctrl
    import or_mul_pkg::*;
#(
    parameter int N = 8,
    parameter logic [(N/4)*(N/4)-1:0] APPROX_MASK = '1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_y,
    output logic           busy
);

    localparam int P  = nibble_count(N);
    localparam int K  = P * P;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int W2 = 2 * N;

    state_e          state_q;
    logic [KW-1:0]   k_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [W2-1:0]   acc_q;
    logic [W2-1:0]   acc_d;

    logic [KW-1:0]   i_w;
    logic [KW-1:0]   j_w;
    logic [NIB-1:0]  a_nib;
    logic [NIB-1:0]  b_nib;
    logic [SUBW-1:0] apx_sub;
    logic [SUBW-1:0] ex_sub;
    logic [SUBW-1:0] sub;

    // k walks the multiplicand nibble fastest: i = k mod P, j = k div P.
    assign i_w   = k_q % KW'(P);
    assign j_w   = k_q / KW'(P);
    assign a_nib = NIB'(a_q >> (NIB * i_w));
    assign b_nib = NIB'(b_q >> (NIB * j_w));

    or_4x4 u_core (
        .a_i (a_nib),
        .b_i (b_nib),
        .p_o (apx_sub)
    );

    assign ex_sub = SUBW'(a_nib) * SUBW'(b_nib);
    assign sub    = APPROX_MASK[k_q] ? apx_sub : ex_sub;
    assign acc_d  = acc_q + (W2'(sub) << (NIB * (i_w + j_w)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    if (k_q == KW'(K - 1)) begin
                        k_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    // Hand-off returns to IDLE only; a new operand pair waits a cycle.
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_y     = acc_q;

endmodule

// File: tb/tb_or_mul_seq_ctrl.sv
// Scoreboard bench: an approximate-mask and an exact-mask instance run in lockstep.
module tb_or_mul_seq_ctrl;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        ir_a, ov_a, busy_a;
    logic        ir_e, ov_e, busy_e;
    logic [15:0] y_a, y_e;

    int tests = 0;
    int fails = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_e[$];

    always #5 clk = ~clk;

    or_mul_seq_ctrl #(.N(N)) dut_apx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a),
        .in_a(in_a), .in_b(in_b), .out_valid(ov_a), .out_ready(out_ready),
        .out_y(y_a), .busy(busy_a)
    );

    or_mul_seq_ctrl #(.N(N), .APPROX_MASK(4'b0000)) dut_ex (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_e),
        .in_a(in_a), .in_b(in_b), .out_valid(ov_e), .out_ready(out_ready),
        .out_y(y_e), .busy(busy_e)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Approximate nibble product: bit p set iff some a[i]&b[j] has i+j==p; top bit always set.
    function automatic logic [7:0] ref_sub(input logic [3:0] a, input logic [3:0] b, input bit apx);
        logic [7:0] r;
        if (!apx) return {4'b0, a} * {4'b0, b};
        r = 8'h80;
        for (int p = 0; p < 7; p++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (i + j == p && a[i] && b[j]) r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic [3:0] mask);
        logic [31:0] acc;
        acc = 0;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 2; i++)
                acc += 32'(ref_sub(4'(a >> (4 * i)), 4'(b >> (4 * j)), mask[j * 2 + i])) << (4 * (i + j));
        return acc[15:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (ov_a) begin
                if (q_a.size() == 0) check("apx_unexpected_output", 32'(y_a), 32'hDEAD_0000);
                else check("apx_out_y", 32'(y_a), 32'(q_a.pop_front()));
            end
            if (ov_e) begin
                if (q_e.size() == 0) check("ex_unexpected_output", 32'(y_e), 32'hDEAD_0000);
                else check("ex_out_y", 32'(y_e), 32'(q_e.pop_front()));
            end
        end
    end

    task automatic handshake(input logic [7:0] a, input logic [7:0] b);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit chk_lat);
        int cyc;
        cyc = 0;
        while (!ov_a && cyc < 50) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (chk_lat) check("latency", 32'(cyc), 32'd4);
        else if (!ov_a) check("valid_timeout", 32'(cyc), 32'd4);
        check("lockstep_valid", 32'(ov_e), 32'(ov_a));
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] ea, input logic [15:0] ee, input bit chk_lat);
        q_a.push_back(ea);
        q_e.push_back(ee);
        handshake(a, b);
        wait_valid(chk_lat);
        @(posedge clk);
        #1 if (chk_lat) check("in_ready_after_handoff", 32'(ir_a), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [7:0] ra, rb;
        logic [15:0] bp_exp;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", 32'(ov_a), 32'd0);
        check("reset_out_y", 32'(y_a), 32'd0);
        check("reset_in_ready", 32'(ir_a), 32'd1);
        check("reset_busy", 32'(busy_a), 32'd0);

        @(posedge clk);
        #1;
        run_op(8'h00, 8'h00, 16'h9080, 16'h0000, 1'b1);
        run_op(8'h33, 8'h33, 16'h9867, 16'h0A29, 1'b1);
        run_op(8'h11, 8'h11, 16'h91A1, 16'h0121, 1'b1);
        run_op(8'hFF, 8'hFF, ref_mul(8'hFF, 8'hFF, 4'hF), 16'hFE01, 1'b1);

        // Backpressure: result must hold while the sink stalls, and new operands are ignored.
        out_ready = 1'b0;
        bp_exp = ref_mul(8'hC7, 8'h3E, 4'hF);
        q_a.push_back(bp_exp);
        q_e.push_back(16'(8'hC7) * 16'(8'h3E));
        handshake(8'hC7, 8'h3E);
        wait_valid(1'b1);
        in_a     = 8'h5A;
        in_b     = 8'hA5;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_out_y", 32'(y_a), 32'(bp_exp));
            check("bp_out_valid", 32'(ov_a), 32'd1);
            check("bp_in_ready", 32'(ir_a), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(ir_a), 32'd1);
        check("bp_release_out_valid", 32'(ov_a), 32'd0);
        check("bp_release_busy", 32'(busy_a), 32'd0);

        // Reset with k=2: the partial product is discarded.
        handshake(8'hFF, 8'hFF);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_out_valid", 32'(ov_a), 32'd0);
        check("midrst_out_y", 32'(y_a), 32'd0);
        check("midrst_in_ready", 32'(ir_a), 32'd1);
        check("midrst_busy", 32'(busy_a), 32'd0);
        run_op(8'h33, 8'h33, 16'h9867, 16'h0A29, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, ref_mul(ra, rb, 4'hF), 16'(ra) * 16'(rb), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("apx_queue_drained", 32'(q_a.size()), 32'd0);
        check("ex_queue_drained", 32'(q_e.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/or_mul_seq_ctrl.md
Name: or_mul_seq_ctrl

Overview:
- Sequential recursive multiplier controller. Time-multiplexes one approximate OR-based 4x4 partial-product core (or_4x4) across all nibble pairs of two N-bit operands.
- Each 8-bit nibble sub-product is shift-accumulated into a 2N-bit result.
- Sits between an upstream valid/ready operand source and a downstream valid/ready result sink.
- Per-quadrant mask selects the approximate core or an exact 4x4 product. This supports accuracy/power exploration.

Parameters:
- N, 8, operand width; legal values 8 or 16 (multiple of 4).
- APPROX_MASK, all ones, (N/4)^2-bit mask.
  - Bit k=1: sub-product k uses or_4x4.
  - Bit k=0: sub-product k uses the exact a_nib*b_nib.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  controller can accept operands
- in_a  input  N  multiplicand
- in_b  input  N  multiplier
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out_y  output  2N  accumulated product
- busy  output  1  high in MUL or DONE

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high (rst). All state is updated on the clk rising edge.
- Reset (rst=1 at an edge), regardless of state, including mid-MUL: state=IDLE, k=0, accumulator=0, latched operands=0.
  - Reset output values: out_valid=0, out_y=0, in_ready=1 (after reset), busy=0.
  - An in-flight operation is discarded; no partial result is emitted.
- Constants: P=N/4 nibbles per operand; K=P*P sub-products.
- Sub-product k, for 0<=k<K:
  - i = k mod P, j = k div P.
  - a_nib = A[4i+3:4i], b_nib = B[4j+3:4j].
  - Shift amount = 4*(i+j).
- States:
  - IDLE: in_ready=1. On in_valid=1, latch A=in_a and B=in_b, clear the accumulator and k, then go to MUL.
  - MUL: in_ready=0. Each cycle, accumulator += zero_ext(sub_k) << 4*(i+j), mod 2^(2N), then k++. When k=K-1 is added, go to DONE.
  - DONE: out_valid=1, out_y=accumulator, held stable. On out_ready=1, go to IDLE (in_ready=1 on the next cycle).
- Sub-product source:
  - APPROX_MASK[k]=1: or_4x4 output. Note that or_4x4 bit 7 is constant 1, so each approximate sub-product is >= 0x80.
  - APPROX_MASK[k]=0: exact 8-bit product.
- Latency: handshake at edge E0; sub-products added at edges E1..EK; out_valid high after EK.
  - N=8: 4 cycles. N=16: 16 cycles.
  - Throughput: one result per K+2 cycles minimum (includes the IDLE cycle).
- Arithmetic: the accumulator is exactly 2N bits and overflow wraps silently. Approximate sums can exceed 2^(2N)-1; no saturation, no flag.
- Boundaries:
  - in_valid is ignored outside IDLE; operands changing mid-MUL have no effect.
  - out_y and out_valid stay stable while out_ready=0 (backpressure is unbounded).
  - out_ready asserted outside DONE is ignored.
  - No bypass: input cannot be accepted in the same cycle as result hand-off.
  - rst has priority over every handshake.
- out_y is registered (driven from the accumulator); no combinational path from inputs to outputs except none; in_ready/out_valid decode state only.

Decomposition:
- Package or_mul_pkg:
  - state enum {IDLE, MUL, DONE}
  - NIB=4, SUBW=8
  - function nibble_count(N)
- Sub-module: single instance of the existing or_4x4 as the shared approximate core. It is fed by mux-selected a_nib/b_nib driven from k.
- Exact product, shift and accumulate stay inline.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release -> out_valid=0, out_y=0x0000, in_ready=1, busy=0.
- N=8, default mask, a=0x00, b=0x00 -> out_valid exactly 4 cycles after handshake, out_y=0x9080 (4 x 0x80 shifted 0, 4, 4, 8).
- N=8, default mask, a=0x33, b=0x33 -> out_y=0x9867 (nibble product 0x87 each). Second operation a=0x11, b=0x11 -> out_y=0x91A1.
- N=8, APPROX_MASK=0, a=0xFF, b=0xFF -> out_y=0xFE01. Random 1000 pairs -> out_y == a*b.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_y stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle.
- Reset mid-MUL: rst at k=2 -> next cycle IDLE, out_valid=0, accumulator=0. A following op with a=0x33, b=0x33 still yields 0x9867.
